stoch_window_counter: RTL and testbench
=======================================

Name: stoch_window_counter

Overview:
- Downstream consumer of a stochastic bitstream: counts the 1s in BIT_IN over a fixed window of enabled clock cycles and converts the stream back to a binary value.
- Registers the result and presents it with a VALID/ACK handshake.
- Supports single-shot and continuous (back-to-back window) operation.
- Replaces gated-clock counting with a fully synchronous, enable-qualified datapath on one clock.

Parameters:
- N, 14, width of the ones counter and of VALUE.
- WINDOW, 16383, samples per window. Legal range is 1 to 2^N-1, so the count can never exceed VALUE width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  begin a window; aborts and restarts a window in progress.
- CONT  in  1  continuous mode; sampled at window end.
- EN  in  1  sample qualifier; BIT_IN is counted only on cycles with EN=1.
- BIT_IN  in  1  stochastic bitstream.
- ACK  in  1  consumer acknowledges VALUE.
- BUSY  out  1  high while in the RUN state.
- DONE  out  1  one-cycle pulse when a window completes.
- VALID  out  1  VALUE holds an unacknowledged result.
- VALUE  out  N  count of 1s in the last completed window.
- OVERRUN  out  1  sticky: a result was overwritten before being acknowledged.

Behaviour:
- Reset (async): state=IDLE. Internal ones_cnt=0, smp_cnt=0. BUSY=0, DONE=0, VALID=0, VALUE=0, OVERRUN=0. Takes effect mid-window, with no result produced.
- States: IDLE, RUN.
- IDLE:
  - START=1 -> RUN; ones_cnt=0, smp_cnt=0, OVERRUN cleared.
  - BIT_IN and EN are ignored.
- RUN, EN=0: counters hold.
- RUN, EN=1, smp_cnt<WINDOW-1: ones_cnt+=BIT_IN, smp_cnt+=1.
- RUN, EN=1, smp_cnt==WINDOW-1 (final sample). At that same edge:
  - VALUE<=ones_cnt+BIT_IN, VALID<=1, DONE<=1 for exactly one cycle.
  - ones_cnt<=0, smp_cnt<=0.
  - If CONT=1, stay in RUN: the next enabled cycle is sample 0 of the next window, with no dead cycle.
  - If CONT=0, go to IDLE.
- Latency: VALUE, VALID and DONE are visible in the cycle following the edge that captured the final sample.
- START in RUN:
  - Counters clear and the window restarts.
  - No DONE, and VALUE/VALID are unchanged.
  - START takes priority over a coinciding final sample: that result is discarded.
- ACK:
  - ACK=1 with VALID=1 clears VALID at the next edge.
  - ACK with VALID=0 is ignored.
- ACK coincident with a new result: the new result wins; VALID stays 1 and VALUE takes the new count. OVERRUN is not set.
- New result while VALID=1 and ACK=0: VALUE is overwritten and OVERRUN<=1.
- OVERRUN is cleared only by RESET or by START from IDLE.
- BUSY = (state==RUN), registered.
- Count range: ones_cnt never exceeds WINDOW, so no saturation logic is needed. All-ones input gives VALUE=WINDOW; all-zeros gives VALUE=0.
- WINDOW=1: every enabled cycle in RUN is a final sample.
- VALUE is stable whenever VALID=1 except on an overwrite edge.

Test Plan:
- Reset mid-window (N=4, WINDOW=10), reset asserted after 5 samples: all outputs 0 immediately; no DONE afterwards until a new START.
- Single shot, BIT_IN pattern 1,0,1,1,0,0,1,1,1,0 with EN=1, CONT=0: DONE pulses once, VALUE=6, VALID=1, BUSY falls; ACK one cycle later -> VALID=0, VALUE still 6.
- EN gaps: same pattern with EN=0 on alternate cycles and BIT_IN=1 during those gaps: VALUE=6, and DONE arrives 19 cycles after the first sample.
- Continuous mode, all-ones stream, CONT=1, no ACK: DONE every 10 cycles, VALUE=10; OVERRUN=1 after the second window. START from IDLE clears OVERRUN.
- ACK coincident with DONE in continuous mode: VALID stays 1 and OVERRUN stays 0.
- START asserted at the final-sample cycle: no DONE, VALUE unchanged, and a new full 10-sample window follows.

Source files
------------

// File: rtl/stoch_window_counter_if.sv
// Handshake bundle between a stochastic-stream producer/consumer and the window counter.
interface stoch_window_counter_if #(
  parameter int unsigned N = 14
);
  logic         start;
  logic         cont;
  logic         en;
  logic         bit_in;
  logic         ack;
  logic         busy;
  logic         done;
  logic         valid;
  logic [N-1:0] value;
  logic         overrun;

  modport master (
    output start, cont, en, bit_in, ack,
    input  busy, done, valid, value, overrun
  );

  modport slave (
    input  start, cont, en, bit_in, ack,
    output busy, done, valid, value, overrun
  );
endinterface

// File: rtl/stoch_window_counter.sv
// Counts 1s of an enable-qualified stochastic bitstream over a fixed window and
// presents the count with a VALID/ACK handshake; single-shot or back-to-back windows.
module stoch_window_counter #(
  parameter int unsigned N      = 14,
  parameter int unsigned WINDOW = 16383
) (
  input logic                    clk,
  input logic                    rst,
  stoch_window_counter_if.slave  bus
);

  localparam logic [0:0]   IDLE = 1'b0;
  localparam logic [0:0]   RUN  = 1'b1;
  localparam logic [N-1:0] LAST = N'(WINDOW - 1);

  logic [0:0]   state_q,   state_d;
  logic [N-1:0] ones_q,    ones_d;
  logic [N-1:0] smp_q,     smp_d;
  logic         busy_q,    busy_d;
  logic         done_q,    done_d;
  logic         valid_q,   valid_d;
  logic [N-1:0] value_q,   value_d;
  logic         overrun_q, overrun_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      smp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      value_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      smp_q     <= smp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, counter and handshake logic
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    smp_d     = smp_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    value_d   = value_q;
    overrun_d = overrun_q;

    if (valid_q && bus.ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          ones_d    = '0;
          smp_d     = '0;
          overrun_d = 1'b0;
        end
      end
      RUN: begin
        // A restart discards any coinciding final sample
        if (bus.start) begin
          ones_d = '0;
          smp_d  = '0;
        end else if (bus.en) begin
          if (smp_q == LAST) begin
            value_d = ones_q + N'(bus.bit_in);
            valid_d = 1'b1;
            done_d  = 1'b1;
            if (valid_q && !bus.ack) begin
              overrun_d = 1'b1;
            end
            ones_d  = '0;
            smp_d   = '0;
            state_d = bus.cont ? RUN : IDLE;
          end else begin
            ones_d = ones_q + N'(bus.bit_in);
            smp_d  = smp_q + N'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.valid   = valid_q;
  assign bus.value   = value_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_stoch_window_counter.sv
// Directed self-checking bench for stoch_window_counter with N=4, WINDOW=10.
module tb_stoch_window_counter;

  localparam int unsigned N      = 4;
  localparam int unsigned WINDOW = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [9:0] pat;

  stoch_window_counter_if #(.N(N)) bus ();

  stoch_window_counter #(.N(N), .WINDOW(WINDOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic b, input logic d,
                            input logic v, input logic [N-1:0] val, input logic o);
    check({tag, ".busy"},    32'(bus.busy),    32'(b));
    check({tag, ".done"},    32'(bus.done),    32'(d));
    check({tag, ".valid"},   32'(bus.valid),   32'(v));
    check({tag, ".value"},   32'(bus.value),   32'(val));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(o));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pat        = 10'b0111001101; // bit i is sample i: 1,0,1,1,0,0,1,1,1,0
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.en     = 1'b0;
    bus.bit_in = 1'b0;
    bus.ack    = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    tick();

    // Reset mid-window after 5 samples
    bus.start = 1'b1;
    tick();
    check("rstmid.busy_run", 32'(bus.busy), 32'd1);
    bus.start  = 1'b0;
    bus.en     = 1'b1;
    bus.bit_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check_outs("rstmid.async", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rstmid.no_done", 32'(bus.done), 32'd0);
    end
    check("rstmid.idle", 32'(bus.busy), 32'd0);

    // Single shot with pattern, then ACK
    bus.en    = 1'b0;
    bus.start = 1'b1;
    tick();
    check("single.busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.bit_in = pat[i];
      tick();
      if (i < 9) check("single.early_done", 32'(bus.done), 32'd0);
    end
    check_outs("single.result", 1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
    bus.en  = 1'b0;
    bus.ack = 1'b1;
    tick();
    check_outs("single.ack", 1'b0, 1'b0, 1'b0, 4'd6, 1'b0);
    bus.ack = 1'b0;

    // Same pattern with EN gaps carrying BIT_IN=1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      if ((k % 2) == 0) begin
        bus.en     = 1'b1;
        bus.bit_in = pat[k/2];
      end else begin
        bus.en     = 1'b0;
        bus.bit_in = 1'b1;
      end
      tick();
      if (k < 18) check("gaps.early_done", 32'(bus.done), 32'd0);
    end
    check_outs("gaps.result", 1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
    bus.en  = 1'b0;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("gaps.acked", 32'(bus.valid), 32'd0);

    // Continuous all-ones, no ACK
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.cont   = 1'b1;
    bus.en     = 1'b1;
    bus.bit_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_outs("cont.win1", 1'b1, 1'b1, 1'b1, 4'd10, 1'b0);
    tick();
    check("cont.done_pulse", 32'(bus.done), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check_outs("cont.win2", 1'b1, 1'b1, 1'b1, 4'd10, 1'b1);
    bus.cont = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_outs("cont.win3", 1'b0, 1'b1, 1'b1, 4'd10, 1'b1);
    bus.en    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("cont.restart", 1'b1, 1'b0, 1'b1, 4'd10, 1'b0);

    // ACK coincident with DONE in continuous mode
    bus.cont   = 1'b1;
    bus.en     = 1'b1;
    bus.bit_in = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_outs("ackdone", 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);

    // START on the final-sample cycle discards that result
    bus.en  = 1'b0;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("startfin.acked", 32'(bus.valid), 32'd0);
    bus.cont   = 1'b0;
    bus.en     = 1'b1;
    bus.bit_in = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("startfin.abort", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("startfin.no_early", 32'(bus.done), 32'd0);
    tick();
    check_outs("startfin.full", 1'b0, 1'b1, 1'b1, 4'd10, 1'b0);
    bus.en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
